port_injector: RTL and testbench
================================

// Module: port_injector
// PURPOSE
//  Transmit-side partner of the port matcher. Rewrites a 16-bit TCP/UDP port field at a programmable byte offset in a
//  32-bit word frame stream, including fields that straddle a word boundary. Drives test frames into the sniffer ingress.
//  Lane order is identical to the matcher's: byte k of a word = data[8k+7:8k]; port[7:0] sits at the lower byte address.
// PARAMETERS
//  OFFW     6    width of port_offset (byte offset into frame, 0..63)
//  CNTW     5    width of word counter; saturates at 2**CNTW-1
// PORTS
//  clk          in   1     clock
//  n_rst        in   1     asynchronous reset, active-low
//  clear        in   1     synchronous flush; same effect as reset
//  enable       in   1     injection enable, sampled on accepted SOF word
//  port_value   in   16    port to write, sampled on accepted SOF word
//  port_offset  in   OFFW  byte offset of port LSB, sampled on accepted SOF word
//  valid_in     in   1     upstream word valid
//  sof_in       in   1     first word of frame (qualified by valid_in)
//  eof_in       in   1     last word of frame (qualified by valid_in)
//  data_in      in   32    upstream word
//  ready_out    out  1     upstream may present next word
//  ready_in     in   1     downstream accepts data_out this cycle
//  valid_out    out  1     data_out valid
//  sof_out      out  1     registered sof
//  eof_out      out  1     registered eof
//  data_out     out  32    word with port inserted
//  inserted     out  1     1-cycle pulse: both port bytes written in current frame
//  frame_short  out  1     1-cycle pulse: EOF reached before both bytes written
// BEHAVIOUR
//  - Reset/clear: valid_out, sof_out, eof_out, inserted, frame_short = 0; data_out = 0; state IDLE; counters 0.
//  - Accept = valid_in & ready_out; ready_out = ready_in | ~valid_out. Output register loads on accept (latency 1).
//  - valid_out & ~ready_in: data_out/sof_out/eof_out hold unchanged.
//  - Word W = port_offset>>2, lane L = port_offset[1:0], latched with port_value/enable at accepted SOF.
//  - FSM IDLE: words without sof pass unmodified. Accepted sof -> IN_FRAME, wcnt = 0.
//  - FSM IN_FRAME: per accepted word, wcnt+1 (saturating). If enable and wcnt==W:
//      L<3: lanes L,L+1 <= port[7:0],port[15:8]; inserted pulses with that output word.
//      L==3: lane 3 <= port[7:0]; -> SPLIT.
//  - FSM SPLIT: next accepted word lane 0 <= port[15:8]; inserted pulses; -> IN_FRAME.
//  - Accepted eof: -> IDLE, after the eof word's own insertion. If no insertion done (still IN_FRAME with wcnt<W, or in
//    SPLIT): frame_short pulses with the eof output word. sof+eof in the same word = one-word frame, same rules.
//  - Accepted sof while IN_FRAME/SPLIT (missing eof): abandon pending byte, relatch config, wcnt = 0. No frame_short.
//  - enable=0 at SOF: frame passes bit-exact; neither pulse fires.
//  - Config changes mid-frame have no effect until next SOF. Reset mid-frame drops the frame; output valid drops at once.
// STRUCTURE
//  - eth_sniffer_pkg: typedef enum {IDLE, IN_FRAME, SPLIT} inj_state_t; localparam TCP_DST_PORT_OFS = 36 (14+20+2);
//    typedef logic [7:0] byte_t.
//  - Sub-module port_lane_writer: combinational lane mux (word, lane mask, two bytes) -> word. All other logic in top.
// TESTING
//  - offset 36, port 16'h1F90, 12-word frame, no stall -> word 9 = {in[31:16],8'h1F,8'h90}; inserted with word 9.
//  - offset 39, port 16'h0050 -> word 9 byte3 = 8'h50, word 10 byte0 = 8'h00; inserted with word 10.
//  - offset 39, eof on word 9 -> byte3 written; frame_short pulses with word 9; next frame SOF starts clean.
//  - ready_in toggles 1010..., offset 6 -> output sequence equals no-stall run; no word lost or duplicated.
//  - enable=0 -> output == input for the whole frame; n_rst low mid-frame -> all outputs 0 the next cycle.
//  - Loopback into port_comparator with flagged_port = inserted value -> match asserts; with enable=0 -> no match.

Source files
------------

// File: rtl/eth_sniffer_pkg.sv
// eth_sniffer_pkg: shared types and constants for the sniffer datapath blocks.
package eth_sniffer_pkg;
    typedef enum logic [1:0] {IDLE, IN_FRAME, SPLIT} inj_state_t;
    typedef logic [7:0] byte_t;
    localparam int TCP_DST_PORT_OFS = 14 + 20 + 2;
endpackage

// File: rtl/port_lane_writer.sv
// port_lane_writer: overwrite masked byte lanes of a word; lane `lane` takes lo, other masked lanes take hi.
module port_lane_writer
    import eth_sniffer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [3:0]  mask,
    input  logic [1:0]  lane,
    input  byte_t       lo,
    input  byte_t       hi,
    output logic [31:0] result
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign result[8*i +: 8] = mask[i] ? ((lane == 2'(i)) ? lo : hi) : word[8*i +: 8];
    end
endmodule

// File: rtl/port_injector.sv
// port_injector: rewrites a 16-bit port field at a byte offset of a 32-bit word frame stream,
// including fields that straddle a word boundary.
module port_injector
    import eth_sniffer_pkg::*;
#(
    parameter int OFFW = 6,
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [15:0]     port_value,
    input  logic [OFFW-1:0] port_offset,
    input  logic            valid_in,
    input  logic            sof_in,
    input  logic            eof_in,
    input  logic [31:0]     data_in,
    output logic            ready_out,
    input  logic            ready_in,
    output logic            valid_out,
    output logic            sof_out,
    output logic            eof_out,
    output logic [31:0]     data_out,
    output logic            inserted,
    output logic            frame_short
);
    inj_state_t state, state_nx, cur;
    logic [CNTW-1:0] wcnt, wcnt_nx, cur_cnt, w_ext;
    logic            en_q, en_c;
    logic [15:0]     port_q, port_c;
    logic [OFFW-1:0] ofs_q, ofs_c;
    logic [1:0]      l_c, lane;
    logic [3:0]      mask;
    logic            accept, hit, split_fin, ins_now, short_now;
    logic [31:0]     data_mod;

    assign ready_out = ready_in | ~valid_out;
    assign accept    = valid_in & ready_out;

    // An SOF word restarts the frame with the live config, so it behaves as word 0 of a fresh IN_FRAME.
    always_comb begin
        cur       = sof_in ? IN_FRAME : state;
        cur_cnt   = sof_in ? '0 : wcnt;
        en_c      = sof_in ? enable : en_q;
        port_c    = sof_in ? port_value : port_q;
        ofs_c     = sof_in ? port_offset : ofs_q;
        l_c       = ofs_c[1:0];
        w_ext     = CNTW'(ofs_c >> 2);
        hit       = en_c && cur == IN_FRAME && cur_cnt == w_ext;
        split_fin = en_c && cur == SPLIT;
        mask      = split_fin ? 4'b0001 : hit ? ((l_c == 2'd3) ? 4'b1000 : 4'b0011 << l_c) : 4'b0000;
        lane      = split_fin ? 2'd3 : l_c;
        ins_now   = split_fin || (hit && l_c != 2'd3);
        short_now = eof_in && en_c && cur != IDLE && !ins_now && !(cur == IN_FRAME && cur_cnt > w_ext);
        state_nx  = eof_in ? IDLE : (hit && l_c == 2'd3) ? SPLIT : (cur == SPLIT) ? IN_FRAME : cur;
        wcnt_nx   = (cur == IDLE) ? wcnt : (&cur_cnt) ? cur_cnt : cur_cnt + 1'b1;
    end

    port_lane_writer u_writer (
        .word   (data_in),
        .mask   (mask),
        .lane   (lane),
        .lo     (port_c[7:0]),
        .hi     (port_c[15:8]),
        .result (data_mod)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            en_q   <= 1'b0;
            port_q <= '0;
            ofs_q  <= '0;
        end else if (clear) begin
            state  <= IDLE;
            wcnt   <= '0;
            en_q   <= 1'b0;
            port_q <= '0;
            ofs_q  <= '0;
        end else if (accept) begin
            state  <= state_nx;
            wcnt   <= wcnt_nx;
            en_q   <= en_c;
            port_q <= port_c;
            ofs_q  <= ofs_c;
        end
    end

    // Flag pulses last one cycle even if the word they mark is held by a stall.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_out   <= 1'b0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            data_out    <= '0;
            inserted    <= 1'b0;
            frame_short <= 1'b0;
        end else if (clear) begin
            valid_out   <= 1'b0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            data_out    <= '0;
            inserted    <= 1'b0;
            frame_short <= 1'b0;
        end else begin
            inserted    <= accept & ins_now;
            frame_short <= accept & short_now;
            if (accept) begin
                valid_out <= 1'b1;
                sof_out   <= sof_in;
                eof_out   <= eof_in;
                data_out  <= data_mod;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_port_injector.sv
// tb_port_injector: directed scenarios for port_injector against a byte-address model of the frame.
module tb_port_injector;
    import eth_sniffer_pkg::*;

    logic        clk = 0, n_rst = 0, clear = 0, enable = 0;
    logic [15:0] port_value = 0;
    logic [5:0]  port_offset = 0;
    logic        valid_in = 0, sof_in = 0, eof_in = 0, ready_in = 1;
    logic [31:0] data_in = 0;
    logic        ready_out, valid_out, sof_out, eof_out, inserted, frame_short;
    logic [31:0] data_out;

    typedef struct packed {logic sof; logic eof; logic [31:0] data;} ow_t;
    ow_t outq[$];
    int  ins_cnt, ins_at, short_cnt, short_at;
    int  vec = 0, errs = 0;

    always #5 clk = ~clk;

    port_injector dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .enable(enable),
        .port_value(port_value), .port_offset(port_offset),
        .valid_in(valid_in), .sof_in(sof_in), .eof_in(eof_in), .data_in(data_in),
        .ready_out(ready_out), .ready_in(ready_in), .valid_out(valid_out),
        .sof_out(sof_out), .eof_out(eof_out), .data_out(data_out),
        .inserted(inserted), .frame_short(frame_short)
    );

    always @(negedge clk) if (n_rst) begin
        if (inserted) begin ins_cnt++; ins_at = outq.size(); end
        if (frame_short) begin short_cnt++; short_at = outq.size(); end
        if (valid_out && ready_in) outq.push_back({sof_out, eof_out, data_out});
    end

    function automatic logic [31:0] in_word(int i);
        return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    // Byte-address model: byte a of the frame has value a unless it is the port field.
    function automatic logic [31:0] exp_word(int i, int ofs, logic [15:0] pv, logic en);
        logic [31:0] w = in_word(i);
        for (int k = 0; k < 4; k++) begin
            if (en && 4*i+k == ofs)   w[8*k +: 8] = pv[7:0];
            if (en && 4*i+k == ofs+1) w[8*k +: 8] = pv[15:8];
        end
        return w;
    endfunction

    // Config is only valid on word 0; later words present conflicting config to prove it is ignored.
    task automatic run_frame(int n, logic [5:0] ofs, logic [15:0] pv, logic en, bit stall, bit with_eof);
        int i = 0, cyc = 0;
        bit tog = 0;
        outq.delete();
        ins_cnt = 0; short_cnt = 0; ins_at = -1; short_at = -1;
        while (i < n && cyc < 1000) begin
            ready_in = stall ? tog : 1'b1;
            tog = ~tog;
            valid_in = 1; sof_in = (i == 0); eof_in = with_eof && (i == n-1); data_in = in_word(i);
            if (i == 0) {enable, port_value, port_offset} = {en, pv, ofs};
            else        {enable, port_value, port_offset} = {~en, 16'hDEAD, ~ofs};
            @(negedge clk);
            if (ready_out) i++;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 1000) begin errs++; $display("FAIL run_frame timeout sent %0d want %0d", i, n); end
        valid_in = 0; sof_in = 0; eof_in = 0; ready_in = 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vec++; if ({valid_out, sof_out, eof_out, inserted, frame_short} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {valid_out, sof_out, eof_out, inserted, frame_short}); end
        vec++; if (data_out !== 32'h0) begin errs++; $display("FAIL reset_data got %h want 0", data_out); end
        @(posedge clk); #1 n_rst = 1;
        @(negedge clk);
        vec++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin errs++; $display("FAIL reset_ready got %b%b want 10", ready_out, valid_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned;
        run_frame(12, 6'(TCP_DST_PORT_OFS), 16'h1F90, 1, 0, 1);
        vec++; if (outq.size() != 12) begin errs++; $display("FAIL aligned_count got %0d want 12", outq.size()); end
        else begin
            vec++; if (outq[9].data !== 32'h27261F90) begin errs++; $display("FAIL aligned_w9 got %h want 27261f90", outq[9].data); end
            for (int i = 0; i < 12; i++) begin
                vec++; if (outq[i] !== {i == 0, i == 11, exp_word(i, 36, 16'h1F90, 1)}) begin errs++; $display("FAIL aligned_w%0d got %h want %h", i, outq[i], {i == 0, i == 11, exp_word(i, 36, 16'h1F90, 1)}); end
            end
        end
        vec++; if (ins_cnt != 1 || ins_at != 9 || short_cnt != 0) begin errs++; $display("FAIL aligned_pulse got ins %0d@%0d short %0d want 1@9 0", ins_cnt, ins_at, short_cnt); end
    endtask

    task automatic test_split;
        run_frame(12, 6'd39, 16'h0050, 1, 0, 1);
        vec++; if (outq.size() != 12) begin errs++; $display("FAIL split_count got %0d want 12", outq.size()); end
        else begin
            vec++; if (outq[9].data !== 32'h50262524) begin errs++; $display("FAIL split_w9 got %h want 50262524", outq[9].data); end
            vec++; if (outq[10].data !== 32'h2B2A2900) begin errs++; $display("FAIL split_w10 got %h want 2b2a2900", outq[10].data); end
            for (int i = 0; i < 12; i++) begin
                vec++; if (outq[i].data !== exp_word(i, 39, 16'h0050, 1)) begin errs++; $display("FAIL split_w%0d got %h want %h", i, outq[i].data, exp_word(i, 39, 16'h0050, 1)); end
            end
        end
        vec++; if (ins_cnt != 1 || ins_at != 10 || short_cnt != 0) begin errs++; $display("FAIL split_pulse got ins %0d@%0d short %0d want 1@10 0", ins_cnt, ins_at, short_cnt); end
    endtask

    task automatic test_short;
        run_frame(10, 6'd39, 16'h0050, 1, 0, 1);
        vec++; if (outq.size() != 10 || outq[9] !== {1'b0, 1'b1, 32'h50262524}) begin errs++; $display("FAIL short_w9 size %0d got %h want 1_50262524", outq.size(), outq[outq.size()-1]); end
        vec++; if (short_cnt != 1 || short_at != 9 || ins_cnt != 0) begin errs++; $display("FAIL short_pulse got short %0d@%0d ins %0d want 1@9 0", short_cnt, short_at, ins_cnt); end
        run_frame(3, 6'd5, 16'h1234, 1, 0, 1);
        vec++; if (outq.size() != 3 || outq[1].data !== 32'h07123404) begin errs++; $display("FAIL short_next_w1 got %h want 07123404", outq[1].data); end
        vec++; if (ins_cnt != 1 || ins_at != 1 || short_cnt != 0) begin errs++; $display("FAIL short_next_pulse got ins %0d@%0d short %0d want 1@1 0", ins_cnt, ins_at, short_cnt); end
    endtask

    task automatic test_stall;
        run_frame(12, 6'd6, 16'hBEEF, 1, 1, 1);
        vec++; if (outq.size() != 12) begin errs++; $display("FAIL stall_count got %0d want 12", outq.size()); end
        else begin
            vec++; if (outq[1].data !== 32'hBEEF0504) begin errs++; $display("FAIL stall_w1 got %h want beef0504", outq[1].data); end
            for (int i = 0; i < 12; i++) begin
                vec++; if (outq[i] !== {i == 0, i == 11, exp_word(i, 6, 16'hBEEF, 1)}) begin errs++; $display("FAIL stall_w%0d got %h want %h", i, outq[i], {i == 0, i == 11, exp_word(i, 6, 16'hBEEF, 1)}); end
            end
        end
        vec++; if (ins_cnt != 1 || ins_at != 1 || short_cnt != 0) begin errs++; $display("FAIL stall_pulse got ins %0d@%0d short %0d want 1@1 0", ins_cnt, ins_at, short_cnt); end
    endtask

    task automatic test_disabled;
        run_frame(12, 6'd36, 16'h1F90, 0, 0, 1);
        vec++; if (outq.size() != 12) begin errs++; $display("FAIL dis_count got %0d want 12", outq.size()); end
        else for (int i = 0; i < 12; i++) begin
            vec++; if (outq[i].data !== in_word(i)) begin errs++; $display("FAIL dis_w%0d got %h want %h", i, outq[i].data, in_word(i)); end
        end
        vec++; if (ins_cnt != 0 || short_cnt != 0) begin errs++; $display("FAIL dis_pulse got ins %0d short %0d want 0 0", ins_cnt, short_cnt); end
    endtask

    task automatic test_one_word;
        run_frame(1, 6'd1, 16'hA55A, 1, 0, 1);
        vec++; if (outq.size() != 1 || outq[0] !== {1'b1, 1'b1, 32'h03A55A00}) begin errs++; $display("FAIL one_ins got %h want 3_03a55a00", outq[0]); end
        vec++; if (ins_cnt != 1 || ins_at != 0 || short_cnt != 0) begin errs++; $display("FAIL one_ins_pulse got ins %0d@%0d short %0d want 1@0 0", ins_cnt, ins_at, short_cnt); end
        run_frame(1, 6'd3, 16'hA55A, 1, 0, 1);
        vec++; if (outq.size() != 1 || outq[0].data !== 32'h5A020100) begin errs++; $display("FAIL one_split got %h want 5a020100", outq[0].data); end
        vec++; if (short_cnt != 1 || short_at != 0 || ins_cnt != 0) begin errs++; $display("FAIL one_split_pulse got short %0d@%0d ins %0d want 1@0 0", short_cnt, short_at, ins_cnt); end
    endtask

    task automatic test_resync;
        run_frame(5, 6'd36, 16'h1F90, 1, 0, 0);
        vec++; if (ins_cnt != 0 || short_cnt != 0) begin errs++; $display("FAIL resync_a_pulse got ins %0d short %0d want 0 0", ins_cnt, short_cnt); end
        run_frame(4, 6'd9, 16'hC0DE, 1, 0, 1);
        vec++; if (outq.size() != 4 || outq[2].data !== 32'h0BC0DE08) begin errs++; $display("FAIL resync_b_w2 got %h want 0bc0de08", outq[2].data); end
        vec++; if (ins_cnt != 1 || ins_at != 2 || short_cnt != 0) begin errs++; $display("FAIL resync_b_pulse got ins %0d@%0d short %0d want 1@2 0", ins_cnt, ins_at, short_cnt); end
    endtask

    task automatic test_reset_mid;
        valid_in = 1; sof_in = 1; eof_in = 0; enable = 1; port_offset = 6'd0; port_value = 16'h9999; data_in = in_word(0);
        @(posedge clk); #1 sof_in = 0; data_in = in_word(1);
        @(posedge clk); #1 n_rst = 0;
        @(negedge clk);
        vec++; if ({valid_out, sof_out, eof_out, inserted, frame_short} !== 5'b0 || data_out !== 32'h0) begin errs++; $display("FAIL rst_mid got %b %h want 00000 0", {valid_out, sof_out, eof_out, inserted, frame_short}, data_out); end
        @(posedge clk); #1 n_rst = 1; sof_in = 1; data_in = in_word(0);
        @(posedge clk); #1 sof_in = 0; clear = 1;
        @(posedge clk); #1 clear = 0; valid_in = 0;
        @(negedge clk);
        vec++; if ({valid_out, sof_out, inserted} !== 3'b0 || data_out !== 32'h0) begin errs++; $display("FAIL clear got %b %h want 000 0", {valid_out, sof_out, inserted}, data_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split();
        test_short();
        test_stall();
        test_disabled();
        test_one_word();
        test_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
